// File: rtl/alu_ctrl_pkg.sv
// Purpose : shared ALU control encodings (select, ALUOp, funct) and the sequencer FSM state type.
// Ports   : none (package).
// Latency/backpressure: n/a.
package alu_ctrl_pkg;

  // 3-bit select understood by the external combinational ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp field from instruction control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  // R-type funct codes that map onto an ALU select
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Purpose : request, ALU-drive and response signal bundle of the ALU op sequencer.
// Ports   : master = sequencer side (drives req_ready, alu_*, rsp_*); slave = control/ALU/consumer side.
// Latency/backpressure: wires only; req and rsp are valid/ready handshakes.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_aluop;
  logic [5:0]       req_funct;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    input  req_valid, req_aluop, req_funct, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    output req_valid, req_aluop, req_funct, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Purpose : combinational (ALUOp, funct) -> ALU select plus illegal-code flag.
// Ports   : aluop_i, funct_i in; sel_o, illegal_o out.
// Latency/backpressure: zero-cycle, no handshake.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] sel_o,
  output logic       illegal_o
);

  always_comb begin
    sel_o     = ALU_ADD;
    illegal_o = 1'b0;
    unique case (aluop_i)
      ALUOP_ADD: sel_o = ALU_ADD;
      ALUOP_SUB: sel_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: sel_o = ALU_ADD;
          FUNCT_SUB: sel_o = ALU_SUB;
          FUNCT_AND: sel_o = ALU_AND;
          FUNCT_OR:  sel_o = ALU_OR;
          FUNCT_SLT: sel_o = ALU_SLT;
          default:   illegal_o = 1'b1;
        endcase
      end
      ALUOP_ILL: illegal_o = 1'b1;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose : issue one decoded op to an external combinational ALU, capture the result, return it with zero/err flags.
// Ports   : clk, rst (sync, active-high); bus (master modport: req/alu/rsp); op_count (completed responses).
// Latency/backpressure: legal op responds WAIT_CYCLES edges after accept, illegal on the accept edge; one op in flight, req_ready low until rsp handshake.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_op_sequencer_if.master   bus,
  output logic [CNT_W-1:0]     op_count
);

  // wait counter must be able to hold WAIT_CYCLES itself (it increments past LAST on the capture edge)
  localparam int              WC_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WAIT_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] opcnt_q, opcnt_d;

  logic [2:0]       dec_sel;
  logic             dec_illegal;

  alu_ctrl_decode u_decode (
    .aluop_i   (bus.req_aluop),
    .funct_i   (bus.req_funct),
    .sel_o     (dec_sel),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      opcnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      opcnt_q <= opcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    opcnt_d = opcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (dec_illegal) begin
            // illegal code skips the ALU entirely; the operand/select registers keep the last legal op
            res_d   = '0;
            zero_d  = 1'b0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            a_d     = bus.req_a;
            b_d     = bus.req_b;
            sel_d   = dec_sel;
            wcnt_d  = '0;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        wcnt_d = wcnt_q + WC_W'(1);
        if (wcnt_q == WC_LAST) begin
          res_d   = bus.alu_result;
          zero_d  = (bus.alu_result == '0);
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          opcnt_d = opcnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_sel    = sel_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;
  assign op_count       = opcnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose : directed + random stimulus for alu_op_sequencer, two instances (WAIT_CYCLES=1/CNT_W=16 and WAIT_CYCLES=4/CNT_W=2).
// Ports   : none; drives both instances through alu_op_sequencer_if and models the team ALU on the alu_* signals.
// Latency/backpressure: expected latency and response values come from an operation-level model of the ALU datapath.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.WIDTH(32)) bus1 ();
  alu_op_sequencer_if #(.WIDTH(32)) bus4 ();
  logic [15:0] op_count1;
  logic [1:0]  op_count4;

  alu_op_sequencer #(.WIDTH(32), .WAIT_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .op_count(op_count1)
  );
  alu_op_sequencer #(.WIDTH(32), .WAIT_CYCLES(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .op_count(op_count4)
  );

  // shared request/response drive; use4 steers the handshakes to one instance
  logic        use4      = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [1:0]  req_aluop = 2'b00;
  logic [5:0]  req_funct = 6'b0;
  logic [31:0] req_a     = 32'b0;
  logic [31:0] req_b     = 32'b0;

  // team ALU behaviour
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    case (s)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign bus1.req_valid  = req_valid & ~use4;
  assign bus4.req_valid  = req_valid & use4;
  assign bus1.rsp_ready  = rsp_ready & ~use4;
  assign bus4.rsp_ready  = rsp_ready & use4;
  assign bus1.req_aluop  = req_aluop;
  assign bus4.req_aluop  = req_aluop;
  assign bus1.req_funct  = req_funct;
  assign bus4.req_funct  = req_funct;
  assign bus1.req_a      = req_a;
  assign bus4.req_a      = req_a;
  assign bus1.req_b      = req_b;
  assign bus4.req_b      = req_b;
  assign bus1.alu_result = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
  assign bus4.alu_result = alu_model(bus4.alu_a, bus4.alu_b, bus4.alu_sel);

  // view of the selected instance
  wire        v_req_ready = use4 ? bus4.req_ready  : bus1.req_ready;
  wire        v_rsp_valid = use4 ? bus4.rsp_valid  : bus1.rsp_valid;
  wire [31:0] v_result    = use4 ? bus4.rsp_result : bus1.rsp_result;
  wire        v_zero      = use4 ? bus4.rsp_zero   : bus1.rsp_zero;
  wire        v_err       = use4 ? bus4.rsp_err    : bus1.rsp_err;
  wire [31:0] v_alu_a     = use4 ? bus4.alu_a      : bus1.alu_a;
  wire [31:0] v_alu_b     = use4 ? bus4.alu_b      : bus1.alu_b;
  wire [2:0]  v_alu_sel   = use4 ? bus4.alu_sel    : bus1.alu_sel;
  wire [15:0] v_op_count  = use4 ? {14'b0, op_count4} : op_count1;

  int checks   = 0;
  int failures = 0;

  // model state, index 0 = dut1, 1 = dut4
  logic [31:0] last_a   [2];
  logic [31:0] last_b   [2];
  logic [2:0]  last_sel [2];
  int          done_cnt [2];

  logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Operation-level reference: what the datapath as a whole should return for a request.
  function automatic void ref_op(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output logic err, output logic [31:0] res, output logic [2:0] sel);
    err = 1'b0; res = 32'd0; sel = 3'b000;
    if (op == 2'b00 || (op == 2'b10 && fn == 6'b100000)) begin res = a + b; sel = 3'b010; end
    else if (op == 2'b01 || (op == 2'b10 && fn == 6'b100010)) begin res = a - b; sel = 3'b110; end
    else if (op == 2'b10 && fn == 6'b100100) begin res = a & b; sel = 3'b000; end
    else if (op == 2'b10 && fn == 6'b100101) begin res = a | b; sel = 3'b001; end
    else if (op == 2'b10 && fn == 6'b101010) begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; sel = 3'b111; end
    else err = 1'b1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      last_a[d] = 32'd0; last_b[d] = 32'd0; last_sel[d] = 3'd0; done_cnt[d] = 0;
    end
  endfunction

  // One request/response round trip on the selected instance; hold = cycles with rsp_ready low
  task automatic do_op(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic        e_err;
    logic [31:0] e_res;
    logic [2:0]  e_sel;
    int          d;
    int          lat;
    int          n;
    d   = use4 ? 1 : 0;
    lat = use4 ? 4 : 1;
    ref_op(op, fn, a, b, e_err, e_res, e_sel);
    chk("req_ready_idle", 32'(v_req_ready), 32'd1);
    req_aluop = op; req_funct = fn; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!e_err) begin last_a[d] = a; last_b[d] = b; last_sel[d] = e_sel; end
    // an illegal code is already responding right after the accept edge
    n = 0;
    while (!v_rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), e_err ? 32'd0 : 32'(lat));
    chk("rsp_result", v_result, e_res);
    chk("rsp_zero", 32'(v_zero), e_err ? 32'd0 : 32'(e_res == 32'd0));
    chk("rsp_err", 32'(v_err), 32'(e_err));
    chk("alu_sel", 32'(v_alu_sel), 32'(last_sel[d]));
    chk("alu_a", v_alu_a, last_a[d]);
    chk("alu_b", v_alu_b, last_b[d]);
    // backpressure: a competing request must not be taken while the response waits
    for (int h = 0; h < hold; h++) begin
      req_aluop = 2'b00; req_a = ~a; req_b = b + 32'd7; req_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(v_rsp_valid), 32'd1);
      chk("hold_result", v_result, e_res);
      chk("hold_req_ready", 32'(v_req_ready), 32'd0);
    end
    req_valid = 1'b0;
    if (hold > 0) chk("hold_alu_a", v_alu_a, last_a[d]);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    done_cnt[d]++;
    chk("rsp_valid_cleared", 32'(v_rsp_valid), 32'd0);
    chk("req_ready_back", 32'(v_req_ready), 32'd1);
    chk("op_count", 32'(v_op_count), use4 ? 32'(done_cnt[d] % 4) : 32'(done_cnt[d] % 65536));
  endtask

  task automatic rand_op(input int hold);
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    op = 2'($urandom_range(0, 3));
    fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)];
    a  = $urandom;
    b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
    do_op(op, fn, a, b, hold);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, 32'(v_req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(v_rsp_valid), 32'd0);
    chk({tag, "_alu_sel"}, 32'(v_alu_sel), 32'd0);
    chk({tag, "_op_count"}, 32'(v_op_count), 32'd0);
    chk({tag, "_rsp_result"}, v_result, 32'd0);
  endtask

  initial begin
    model_reset();
    // reset held two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    use4 = 1'b0; check_reset_state("rst1");
    use4 = 1'b1; check_reset_state("rst4");
    use4 = 1'b0;

    // directed ops on the WAIT_CYCLES=1 instance
    do_op(2'b10, 6'b100000, 32'd224, 32'd282, 0);   // add -> 506
    do_op(2'b10, 6'b100010, 32'd224, 32'd282, 0);   // sub -> 0xFFFFFFC6
    do_op(2'b10, 6'b101010, 32'd224, 32'd282, 0);   // slt -> 1
    chk("slt_value", bus1.rsp_result, 32'd1);
    do_op(2'b10, 6'b100100, 32'd3421, 32'd89, 0);   // and -> 89
    do_op(2'b10, 6'b100101, 32'd3421, 32'd89, 0);   // or -> 3421
    do_op(2'b01, 6'b000000, 32'd224, 32'd224, 0);   // sub equal -> 0, zero
    do_op(2'b10, 6'b000000, 32'd5, 32'd6, 0);       // illegal funct
    do_op(2'b11, 6'b100000, 32'd9, 32'd10, 0);      // illegal aluop
    do_op(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd1, 5); // backpressure, wraps to 0
    for (int i = 0; i < 20; i++) rand_op(i % 3);

    // WAIT_CYCLES=4 instance: latency, then reset mid-EXEC, then counter wrap
    use4 = 1'b1;
    do_op(2'b00, 6'b0, 32'd100, 32'd23, 0);
    do_op(2'b10, 6'b000111, 32'd1, 32'd2, 1);
    for (int i = 0; i < 4; i++) rand_op(i % 2);
    req_aluop = 2'b00; req_a = 32'd1; req_b = 32'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("exec_busy_req_ready", 32'(v_req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("exec_rst_req_ready", 32'(v_req_ready), 32'd1);
    chk("exec_rst_op_count", 32'(v_op_count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("exec_rst_no_rsp", 32'(v_rsp_valid), 32'd0);
    end
    for (int i = 0; i < 5; i++) rand_op(0);
    chk("wrap_op_count", 32'(op_count4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
